// File: rtl/ifetch_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module      : ifetch_buffer_if
//  Description : Bundle of the fetch front end's bus signals.
//                - instruction memory side : imem_req, imem_addr, imem_rdata
//                - core redirect side      : redirect, redirect_pc
//                - core consume side       : inst_valid, inst, inst_pc,
//                                            inst_ready
//                master : the fetch front end (ifetch_buffer)
//                slave  : the surrounding memory + core
//  Revision    : 1.0  initial release
// ============================================================================
interface ifetch_buffer_if #(
  parameter int unsigned IMEM_AW = 10
);
  logic               imem_req;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_rdata;
  logic               redirect;
  logic [31:0]        redirect_pc;
  logic               inst_valid;
  logic [31:0]        inst;
  logic [31:0]        inst_pc;
  logic               inst_ready;

  modport master (
    output imem_req, imem_addr,
    input  imem_rdata,
    input  redirect, redirect_pc,
    output inst_valid, inst, inst_pc,
    input  inst_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_rdata,
    output redirect, redirect_pc,
    input  inst_valid, inst, inst_pc,
    output inst_ready
  );
endinterface
`default_nettype wire

// File: rtl/ifetch_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : ifetch_buffer
//  Description : Instruction fetch front end. Owns the fetch PC, drives a
//                one-cycle-latency instruction memory, buffers returned words
//                with their PCs in a DEPTH-entry FIFO and hands them to the
//                core over a valid/ready handshake. A redirect flushes the
//                FIFO, drops any in-flight read and restarts at redirect_pc.
//  Ports       : clk  - clock, rising edge
//                rst  - synchronous reset, active low
//                bus  - ifetch_buffer_if.master (imem, redirect, inst bus)
//  Options     : IFETCH_BYPASS_EN - when defined, a response arriving with an
//                empty FIFO is presented combinationally in its arrival cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module ifetch_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned IMEM_AW  = 10,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  wire logic         clk,
  input  wire logic         rst,
  ifetch_buffer_if.master   bus
);

  localparam int unsigned   PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned   CNT_W     = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0] DEPTH_OCC = (CNT_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic               inflight_q, inflight_d;
  logic [31:0]        inflight_pc_q, inflight_pc_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [31:0]        pc_mem_q   [DEPTH];
  logic [31:0]        pc_mem_d   [DEPTH];
  logic [31:0]        word_mem_q [DEPTH];
  logic [31:0]        word_mem_d [DEPTH];

  logic [31:0]        redirect_pc_aligned;
  logic [CNT_W:0]     occ_now;
  logic [CNT_W:0]     occ_next;
  logic               req;
  logic               resp;
  logic               fifo_nonempty;
  logic               bypass;
  logic               push;
  logic               pop;
  logic               out_valid;
  logic [31:0]        out_inst;
  logic [31:0]        out_pc;

  always_comb begin
    // Masking (rather than slicing) keeps every redirect_pc bit referenced.
    redirect_pc_aligned = bus.redirect_pc & 32'hFFFF_FFFC;

    // Credit counts buffered words plus the outstanding read; a pop in this
    // cycle is deliberately not credited so the request path stays short.
    occ_now       = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
    req           = (state_q != ST_BOOT) && !bus.redirect && (occ_now < DEPTH_OCC);
    resp          = inflight_q && !bus.redirect;
    fifo_nonempty = (count_q != '0);

`ifdef IFETCH_BYPASS_EN
    bypass = resp && !fifo_nonempty;
`else
    bypass = 1'b0;
`endif

    out_valid = fifo_nonempty || bypass;
    out_inst  = '0;
    out_pc    = '0;
    if (fifo_nonempty) begin
      out_inst = word_mem_q[rd_ptr_q];
      out_pc   = pc_mem_q[rd_ptr_q];
    end else if (bypass) begin
      out_inst = bus.imem_rdata;
      out_pc   = inflight_pc_q;
    end

    // A bypassed word taken by the core never enters the FIFO.
    pop  = fifo_nonempty && bus.inst_ready;
    push = resp && !(bypass && bus.inst_ready);

    fetch_pc_d    = fetch_pc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    pc_mem_d      = pc_mem_q;
    word_mem_d    = word_mem_q;

    if (bus.redirect) begin
      fetch_pc_d = redirect_pc_aligned;
      inflight_d = 1'b0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        pc_mem_d[wr_ptr_q]   = inflight_pc_q;
        word_mem_d[wr_ptr_q] = bus.imem_rdata;
        wr_ptr_d             = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      // The read is outstanding for exactly one cycle.
      inflight_d = req;
      if (req) begin
        inflight_pc_d = fetch_pc_q;
        fetch_pc_d    = fetch_pc_q + 32'd4;
      end
    end

    occ_next = {1'b0, count_d} + {{CNT_W{1'b0}}, inflight_d};

    state_d = state_q;
    case (state_q)
      ST_BOOT: state_d = ST_FETCH;
      ST_FETCH,
      ST_HOLD: state_d = (occ_next < DEPTH_OCC) ? ST_FETCH : ST_HOLD;
      default: state_d = ST_FETCH;
    endcase
    if (bus.redirect) begin
      state_d = ST_FETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_BOOT;
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]   <= '0;
        word_mem_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      pc_mem_q      <= pc_mem_d;
      word_mem_q    <= word_mem_d;
    end
  end

  assign bus.imem_req   = req;
  assign bus.imem_addr  = fetch_pc_q[IMEM_AW+1:2];
  assign bus.inst_valid = out_valid;
  assign bus.inst       = out_inst;
  assign bus.inst_pc    = out_pc;

endmodule
`default_nettype wire
